// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: owns the PC, talks to instruction memory over a
// busywait handshake, and holds the IF/ID register feeding the decoder.
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        STALL,
   input  logic        BRANCH_TAKEN,
   input  logic [31:0] BRANCH_TARGET,
   output logic [31:0] IMEM_ADDR,
   output logic        IMEM_READ,
   input  logic [31:0] IMEM_READDATA,
   input  logic        IMEM_BUSYWAIT,
   output logic        FETCH_BUSY,
   output logic [31:0] PC_OUT,
   output logic [31:0] PC_PLUS4_OUT,
   output logic [31:0] INSTRUCTION,
   output logic        INSTR_VALID
);

   localparam logic [31:0] BUBBLE_PC  = 32'h0000_0000;
   localparam logic [31:0] BUBBLE_PC4 = 32'h0000_0004;
   localparam logic [31:0] PC_STEP    = 32'h0000_0004;
   localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

   typedef enum logic {
      ST_REQ   = 1'b0,
      ST_DRAIN = 1'b1
   } state_t;

   state_t      state;
   logic [31:0] pc;
   logic [31:0] pend;
   logic [31:0] skid_pc;
   logic [31:0] skid_instr;
   logic        skid_valid;
   logic [31:0] if_pc;
   logic [31:0] if_pc4;
   logic [31:0] if_instr;
   logic        if_valid;

   logic        fetch_done;
   logic        fetch_wait;
   logic [31:0] target;
   logic [31:0] pc_inc;
   logic [31:0] skid_pc_inc;

   // No new request while the skid holds a word; DRAIN always keeps its request up.
   assign IMEM_READ   = ~RESET & (((state == ST_REQ) & ~skid_valid) | (state == ST_DRAIN));
   assign IMEM_ADDR   = pc;
   assign fetch_wait  = IMEM_READ & IMEM_BUSYWAIT;
   assign fetch_done  = IMEM_READ & ~IMEM_BUSYWAIT;
   assign FETCH_BUSY  = fetch_wait;

   assign target      = BRANCH_TARGET & ALIGN_MASK;
   assign pc_inc      = pc + PC_STEP;
   assign skid_pc_inc = skid_pc + PC_STEP;

   assign PC_OUT       = if_pc;
   assign PC_PLUS4_OUT = if_pc4;
   assign INSTRUCTION  = if_instr;
   assign INSTR_VALID  = if_valid;

   // PC, skid buffer, redirect state and IF/ID register.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state      <= ST_REQ;
         pc         <= RESET_PC;
         pend       <= RESET_PC;
         skid_pc    <= BUBBLE_PC;
         skid_instr <= NOP_INSTR;
         skid_valid <= 1'b0;
         if_pc      <= BUBBLE_PC;
         if_pc4     <= BUBBLE_PC4;
         if_instr   <= NOP_INSTR;
         if_valid   <= 1'b0;
      end else begin
         case (state)
            ST_REQ: begin
               if (BRANCH_TAKEN) begin
                  if_pc      <= BUBBLE_PC;
                  if_pc4     <= BUBBLE_PC4;
                  if_instr   <= NOP_INSTR;
                  if_valid   <= 1'b0;
                  skid_valid <= 1'b0;
                  // The address must stay put until an outstanding request completes.
                  if (fetch_wait) begin
                     pend  <= target;
                     state <= ST_DRAIN;
                  end else begin
                     pc <= target;
                  end
               end else if (skid_valid) begin
                  if (!STALL) begin
                     if_pc      <= skid_pc;
                     if_pc4     <= skid_pc_inc;
                     if_instr   <= skid_instr;
                     if_valid   <= 1'b1;
                     skid_valid <= 1'b0;
                  end
               end else if (fetch_done) begin
                  pc <= pc_inc;
                  if (STALL) begin
                     skid_pc    <= pc;
                     skid_instr <= IMEM_READDATA;
                     skid_valid <= 1'b1;
                  end else begin
                     if_pc    <= pc;
                     if_pc4   <= pc_inc;
                     if_instr <= IMEM_READDATA;
                     if_valid <= 1'b1;
                  end
               end else if (!STALL) begin
                  if_pc    <= BUBBLE_PC;
                  if_pc4   <= BUBBLE_PC4;
                  if_instr <= NOP_INSTR;
                  if_valid <= 1'b0;
               end
            end

            ST_DRAIN: begin
               if_pc    <= BUBBLE_PC;
               if_pc4   <= BUBBLE_PC4;
               if_instr <= NOP_INSTR;
               if_valid <= 1'b0;
               if (BRANCH_TAKEN) begin
                  pend <= target;
               end
               // The drained word belongs to the abandoned path and is dropped.
               if (fetch_done) begin
                  pc    <= BRANCH_TAKEN ? target : pend;
                  state <= ST_REQ;
               end
            end

            default: begin
               state <= ST_REQ;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: expected IF/ID words are queued
// by the stimulus and retired by a monitor as the decoder would consume them.
module tb_instruction_fetch_unit;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic [31:0] imem_addr;
   logic        imem_read;
   logic [31:0] imem_readdata;
   logic        imem_busywait;
   logic        fetch_busy;
   logic [31:0] pc_out;
   logic [31:0] pc_plus4_out;
   logic [31:0] instruction;
   logic        instr_valid;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] pc4;
      logic [31:0] instr;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;
   logic mon_en = 1'b0;
   logic stall_q = 1'b0;
   logic reset_q = 1'b1;

   instruction_fetch_unit dut (
      .CLK           (clk),
      .RESET         (reset),
      .STALL         (stall),
      .BRANCH_TAKEN  (branch_taken),
      .BRANCH_TARGET (branch_target),
      .IMEM_ADDR     (imem_addr),
      .IMEM_READ     (imem_read),
      .IMEM_READDATA (imem_readdata),
      .IMEM_BUSYWAIT (imem_busywait),
      .FETCH_BUSY    (fetch_busy),
      .PC_OUT        (pc_out),
      .PC_PLUS4_OUT  (pc_plus4_out),
      .INSTRUCTION   (instruction),
      .INSTR_VALID   (instr_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory word is address-tagged so every fetch is distinguishable.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a << 8) | 32'h0000_0013;
   endfunction

   assign imem_readdata = mem_word(imem_addr);

   function automatic void push(input logic [31:0] pc);
      exp_t e;
      e.pc    = pc;
      e.pc4   = pc + 32'd4;
      e.instr = mem_word(pc);
      exp_q.push_back(e);
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
      end
   endtask

   // Drive inputs for the next rising edge, then let combinational outputs settle.
   task automatic cyc(input logic r, input logic s, input logic br,
                      input logic [31:0] tgt, input logic busy);
      @(negedge clk);
      reset         = r;
      stall         = s;
      branch_taken  = br;
      branch_target = tgt;
      imem_busywait = busy;
      #1;
   endtask

   always @(posedge clk) begin
      stall_q <= stall;
      reset_q <= reset;
   end

   // A new valid word lands in IF/ID only on an edge without STALL.
   always @(negedge clk) begin
      if (mon_en && !reset_q && instr_valid === 1'b1 && !stall_q) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_instr got_pc=%h got_instr=%h", pc_out, instruction);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("sb_pc", pc_out, e.pc);
            chk("sb_pc4", pc_plus4_out, e.pc4);
            chk("sb_instr", instruction, e.instr);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog_timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1; stall = 1'b0; branch_taken = 1'b0;
      branch_target = 32'h0; imem_busywait = 1'b0;

      // Reset
      cyc(1, 0, 0, 32'h0, 0);
      chk("rst_read_lo", 32'(imem_read), 32'h0);
      cyc(1, 0, 0, 32'h0, 0);
      chk("rst_read_lo2", 32'(imem_read), 32'h0);
      cyc(0, 0, 0, 32'h0, 0);
      chk("rst_valid", 32'(instr_valid), 32'h0);
      chk("rst_instr", instruction, 32'h0000_0013);
      chk("rst_pc_out", pc_out, 32'h0);
      chk("rst_pc4", pc_plus4_out, 32'h4);
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_read_hi", 32'(imem_read), 32'h1);
      mon_en = 1'b1;
      push(32'h0); push(32'h4); push(32'h8); push(32'hC);

      // Zero-wait fetch, then two busywait cycles on PC=8
      cyc(0, 0, 0, 32'h0, 0);
      cyc(0, 0, 0, 32'h0, 1);
      chk("bw_addr0", imem_addr, 32'h8);
      chk("bw_busy0", 32'(fetch_busy), 32'h1);
      cyc(0, 0, 0, 32'h0, 1);
      chk("bw_addr1", imem_addr, 32'h8);
      chk("bw_busy1", 32'(fetch_busy), 32'h1);
      chk("bw_bubble0", 32'(instr_valid), 32'h0);
      cyc(0, 0, 0, 32'h0, 0);
      chk("bw_addr2", imem_addr, 32'h8);
      chk("bw_busy2", 32'(fetch_busy), 32'h0);
      chk("bw_bubble1", 32'(instr_valid), 32'h0);
      cyc(0, 0, 0, 32'h0, 0);

      // Three-cycle stall; fetch of 0x10 completes into the skid
      cyc(0, 1, 0, 32'h0, 0);
      chk("st_read0", 32'(imem_read), 32'h1);
      chk("st_addr0", imem_addr, 32'h10);
      push(32'h10); push(32'h14);
      cyc(0, 1, 0, 32'h0, 0);
      chk("st_read1", 32'(imem_read), 32'h0);
      chk("st_hold_pc", pc_out, 32'hC);
      cyc(0, 1, 0, 32'h0, 0);
      chk("st_read2", 32'(imem_read), 32'h0);
      chk("st_hold_instr", instruction, mem_word(32'hC));
      cyc(0, 0, 0, 32'h0, 0);
      chk("st_read3", 32'(imem_read), 32'h0);
      cyc(0, 0, 0, 32'h0, 0);
      chk("st_resume_addr", imem_addr, 32'h14);
      chk("st_resume_read", 32'(imem_read), 32'h1);

      // Taken branch to misaligned 0x103 with no wait
      cyc(0, 0, 1, 32'h103, 0);
      push(32'h100);
      cyc(0, 0, 0, 32'h0, 0);
      chk("br_bubble", 32'(instr_valid), 32'h0);
      chk("br_addr", imem_addr, 32'h100);

      // Branch to 0x200 while 0x40 is stalled in memory
      cyc(0, 0, 1, 32'h40, 0);
      cyc(0, 0, 0, 32'h0, 1);
      chk("dr_pre_addr", imem_addr, 32'h40);
      cyc(0, 0, 1, 32'h200, 1);
      cyc(0, 0, 0, 32'h0, 1);
      chk("dr_addr0", imem_addr, 32'h40);
      chk("dr_read", 32'(imem_read), 32'h1);
      chk("dr_bubble", 32'(instr_valid), 32'h0);
      chk("dr_busy", 32'(fetch_busy), 32'h1);
      push(32'h200);
      cyc(0, 0, 0, 32'h0, 0);
      chk("dr_addr1", imem_addr, 32'h40);
      cyc(0, 0, 0, 32'h0, 0);
      chk("dr_redirect", imem_addr, 32'h200);
      chk("dr_discard", 32'(instr_valid), 32'h0);

      // Second branch during DRAIN overrides the pending target
      cyc(0, 0, 1, 32'h500, 1);
      push(32'h300);
      cyc(0, 0, 1, 32'h300, 1);
      chk("dr2_addr0", imem_addr, 32'h204);
      cyc(0, 0, 0, 32'h0, 0);
      chk("dr2_addr1", imem_addr, 32'h204);
      cyc(0, 0, 0, 32'h0, 0);
      chk("dr2_redirect", imem_addr, 32'h300);

      // Reset aborts DRAIN
      cyc(0, 0, 1, 32'h600, 1);
      cyc(1, 0, 0, 32'h0, 1);
      chk("rd_read_lo", 32'(imem_read), 32'h0);
      chk("rd_held_addr", imem_addr, 32'h304);
      cyc(0, 0, 0, 32'h0, 0);
      chk("rd_addr", imem_addr, 32'h0);
      chk("rd_valid", 32'(instr_valid), 32'h0);
      chk("rd_read_hi", 32'(imem_read), 32'h1);
      chk("rd_pc_out", pc_out, 32'h0);
      push(32'h0); push(32'h4);
      cyc(0, 0, 0, 32'h0, 0);

      // Branch to the top of the address space; PC and PC+4 wrap
      cyc(0, 0, 1, 32'hFFFF_FFFE, 0);
      push(32'hFFFF_FFFC); push(32'h0);
      cyc(0, 0, 0, 32'h0, 0);
      chk("wr_addr", imem_addr, 32'hFFFF_FFFC);
      cyc(0, 0, 0, 32'h0, 0);
      chk("wr_addr_wrap", imem_addr, 32'h0);

      // Idle with memory busy so no further words retire
      cyc(0, 0, 0, 32'h0, 1);
      repeat (4) cyc(0, 0, 0, 32'h0, 1);
      chk("sb_drained", 32'(exp_q.size()), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
